// File: rtl/safe_pkg.sv
// Shared types and constants for the safe-cracking round controller.
// Contents: round state enum, code geometry, attempt limit, two-digit BCD type
// and the saturating BCD increment used by the attempt counter and the FSM.
package safe_pkg;

    localparam int DIGITS    = 4;
    localparam int CODE_W    = 2 * DIGITS;
    localparam int MAX_TRIES = 99;

    // [1] = tens, [0] = ones
    typedef logic [1:0][3:0] bcd2_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } state_t;

    localparam bcd2_t MAX_BCD = {4'(MAX_TRIES / 10), 4'(MAX_TRIES % 10)};

    // Increment by one in BCD; holds once the attempt limit is reached.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        r = v;
        if (v != MAX_BCD) begin
            if (v[0] == 4'd9) begin
                r[0] = 4'd0;
                r[1] = v[1] + 4'd1;
            end else begin
                r[0] = v[0] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/safe_round_ctrl_bcd2_counter.sv
// Two-digit BCD attempt counter, saturating at the attempt limit.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, clears count
//   clr    in   synchronous clear (round restart)
//   inc    in   count one attempt
//   count  out  registered BCD count {tens, ones}
module bcd2_counter
    import safe_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  inc,
    output bcd2_t count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= bcd2_inc(count);
        end
    end

endmodule

// File: rtl/safe_round_ctrl.sv
// Round controller for the safe-cracking game: freezes the secret at round
// start, scores submitted guesses, counts attempts in BCD and decides WIN/LOSE.
// Optional build macro: SAFE_REPEAT_FILTER_EN -- a guess identical to the
// previously scored one is still reported but does not cost an attempt.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, submit              one-cycle key pulses
//   rng_code, guess            LFSR value, current guess (CODE_W)
//   n_correct, n_misplaced     checker results for guess vs secret
//   secret                     frozen code (to the checker)
//   tries                      BCD attempt count {tens, ones}
//   last_correct/misplaced     results of the last scored guess
//   eval_valid                 one-cycle pulse after each scored guess
//   playing, win, lose         round status flags
//
// state | meaning
// IDLE  | after reset, waiting for start
// PLAY  | round running, submits are scored
// WIN   | last scored guess was fully correct, outputs held
// LOSE  | attempt limit used up, outputs held
module safe_round_ctrl
    import safe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              submit,
    input  logic [CODE_W-1:0] rng_code,
    input  logic [CODE_W-1:0] guess,
    input  logic [3:0]        n_correct,
    input  logic [3:0]        n_misplaced,
    output logic [CODE_W-1:0] secret,
    output logic [7:0]        tries,
    output logic [3:0]        last_correct,
    output logic [3:0]        last_misplaced,
    output logic              eval_valid,
    output logic              playing,
    output logic              win,
    output logic              lose
);

    state_t state;
    logic   take_start;
    logic   scored;
    logic   counted;
    logic   repeat_guess;
    logic   is_win;
    bcd2_t  next_tries;

    // start is only honoured outside PLAY; this also drops a same-cycle submit
    // in IDLE since scoring only happens in PLAY.
    assign take_start = start && (state != PLAY);
    assign scored     = submit && (state == PLAY);
    assign counted    = scored && !repeat_guess;
    assign is_win     = (n_correct == 4'(DIGITS));
    assign next_tries = bcd2_inc(tries);

`ifdef SAFE_REPEAT_FILTER_EN
    logic [CODE_W-1:0] guess_q;
    logic              guess_seen;

    // guess_seen keeps the first submit of a round counted even when the
    // guess happens to equal the cleared register value.
    assign repeat_guess = guess_seen && (guess == guess_q);

    always_ff @(posedge clk) begin
        if (reset || take_start) begin
            guess_q    <= '0;
            guess_seen <= 1'b0;
        end else if (scored) begin
            guess_q    <= guess;
            guess_seen <= 1'b1;
        end
    end
`else
    assign repeat_guess = 1'b0;
`endif

    bcd2_counter u_tries (
        .clk   (clk),
        .reset (reset),
        .clr   (take_start),
        .inc   (counted),
        .count (tries)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            secret         <= '0;
            last_correct   <= '0;
            last_misplaced <= '0;
            eval_valid     <= 1'b0;
            playing        <= 1'b0;
            win            <= 1'b0;
            lose           <= 1'b0;
        end else begin
            eval_valid <= 1'b0;
            case (state)
                PLAY: begin
                    if (submit) begin
                        last_correct   <= n_correct;
                        last_misplaced <= n_misplaced;
                        eval_valid     <= 1'b1;
                        // Win outranks the limit; a filtered repeat never loses.
                        if (is_win) begin
                            state   <= WIN;
                            playing <= 1'b0;
                            win     <= 1'b1;
                        end else if (counted && (next_tries == MAX_BCD)) begin
                            state   <= LOSE;
                            playing <= 1'b0;
                            lose    <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state          <= PLAY;
                        secret         <= rng_code;
                        last_correct   <= '0;
                        last_misplaced <= '0;
                        playing        <= 1'b1;
                        win            <= 1'b0;
                        lose           <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
